// File: rtl/req_encoder_rr.sv
// req_encoder_rr: registered request encoder with a single output stage.
// Grants the lowest set request (fixed mode) or the first set request at or
// after the rotating pointer (round-robin mode). Results travel with a
// valid/ready handshake on both sides.
module req_encoder_rr #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         rr_en,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_none
);

    localparam int unsigned CW = W + 1;

    // Round-robin start position; always holds a value in 0..N-1
    logic [W-1:0] ptr;

    logic         capture;
    logic [W-1:0] start;
    logic [CW-1:0] cand;
    logic         win_found;
    logic [W-1:0] win_idx;
    logic [N-1:0] win_onehot;
    logic [W-1:0] ptr_next;

    // Output register frees up when empty or when its result is being taken
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    // Search for the first set request starting at 'start', wrapping at N-1
    always_comb begin
        start     = rr_en ? ptr : '0;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = CW'(start) + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!win_found && req[cand[W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[W-1:0];
            end
        end
    end

    // One-hot grant and the pointer position just past the winner
    always_comb begin
        win_onehot = '0;
        ptr_next   = '0;
        if (win_found) begin
            win_onehot = N'(1) << win_idx;
        end
        if (win_idx != W'(N - 1)) begin
            ptr_next = win_idx + W'(1);
        end
    end

    // Output register and pointer; reset wins over capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            out_none   <= 1'b0;
            ptr        <= '0;
        end else begin
            if (capture) begin
                out_valid  <= 1'b1;
                out_idx    <= win_idx;
                out_onehot <= win_onehot;
                out_none   <= !win_found;
                if (rr_en && win_found) begin
                    ptr <= ptr_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_req_encoder_rr.sv
// Bench for req_encoder_rr (N=4): directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// behavioural model.
module tb_req_encoder_rr;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         rr_en;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic         out_none;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_live  = 1'b0;
    bit m_valid = 1'b0;
    int m_idx   = 0;
    int m_oh    = 0;
    bit m_none  = 1'b0;
    int m_ptr   = 0;

    req_encoder_rr #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .rr_en      (rr_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_none   (out_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: sample inputs on the rising edge, then compare DUT just after it
    always @(posedge clk) begin
        int start;
        int win;
        bit acc;
        if (!rst_n) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_idx   = 0;
            m_oh    = 0;
            m_none  = 1'b0;
            m_ptr   = 0;
        end else if (m_live) begin
            acc = in_valid && (!m_valid || out_ready);
            if (acc) begin
                start = rr_en ? m_ptr : 0;
                win   = -1;
                for (int k = 0; k < int'(N); k++) begin
                    if (win < 0 && req[(start + k) % int'(N)]) win = (start + k) % int'(N);
                end
                m_valid = 1'b1;
                if (win < 0) begin
                    m_none = 1'b1;
                    m_idx  = 0;
                    m_oh   = 0;
                end else begin
                    m_none = 1'b0;
                    m_idx  = win;
                    m_oh   = 1 << win;
                    if (rr_en) m_ptr = (win + 1) % int'(N);
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
        if (m_live) begin
            chk("model out_valid", int'(out_valid), int'(m_valid));
            chk("model in_ready", int'(in_ready), int'(!m_valid || out_ready));
            chk("model out_idx", int'(out_idx), m_idx);
            chk("model out_onehot", int'(out_onehot), m_oh);
            chk("model out_none", int'(out_none), int'(m_none));
        end
    end

    // Drive one cycle of inputs at the falling edge, return just after the rising edge
    task automatic cyc(input logic r, input logic [N-1:0] q, input logic m,
                       input logic v, input logic o);
        @(negedge clk);
        rst_n = r; req = q; rr_en = m; in_valid = v; out_ready = o;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_res(input string name, input int v, input int idx,
                              input int oh, input int none);
        chk({name, " valid"}, int'(out_valid), v);
        chk({name, " idx"}, int'(out_idx), idx);
        chk({name, " onehot"}, int'(out_onehot), oh);
        chk({name, " none"}, int'(out_none), none);
    endtask

    initial begin
        int rr_seq[5];
        rr_seq = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; req = '0; rr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // Reset
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        expect_res("reset", 0, 0, 0, 0);
        cyc(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("in_ready after reset", int'(in_ready), 1);

        // Fixed priority
        cyc(1'b1, 4'b0110, 1'b0, 1'b1, 1'b1);
        expect_res("fixed 0110", 1, 1, 4'b0010, 0);

        // Zero request in rr mode leaves ptr at 0
        cyc(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
        expect_res("zero req", 1, 0, 0, 1);

        // Round-robin rotation with wrap
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
            expect_res("rr rotate", 1, rr_seq[i], 1 << rr_seq[i], 0);
        end
        // ptr=1 now; grant 2 moves ptr to 3, then 0101 from 3 wraps to 0
        cyc(1'b1, 4'b0100, 1'b1, 1'b1, 1'b1);
        expect_res("rr to ptr3", 1, 2, 4'b0100, 0);
        cyc(1'b1, 4'b0101, 1'b1, 1'b1, 1'b1);
        expect_res("rr wrap 0101", 1, 0, 4'b0001, 0);
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
        expect_res("rr ptr1", 1, 1, 4'b0010, 0);

        // Backpressure: drain, capture, then hold with changing req
        cyc(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        chk("drained", int'(out_valid), 0);
        cyc(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);
        expect_res("bp capture", 1, 3, 4'b1000, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, N'($urandom), 1'($urandom), 1'b1, 1'b0);
            chk("bp in_ready", int'(in_ready), 0);
            expect_res("bp hold", 1, 3, 4'b1000, 0);
        end
        cyc(1'b1, 4'b0001, 1'b0, 1'b1, 1'b1);
        expect_res("back-to-back", 1, 0, 4'b0001, 0);

        // Mode switch: ptr=3 after rr grant of 2, fixed holds it
        cyc(1'b1, 4'b0100, 1'b1, 1'b1, 1'b1);
        expect_res("ms rr", 1, 2, 4'b0100, 0);
        cyc(1'b1, 4'b1100, 1'b0, 1'b1, 1'b1);
        expect_res("ms fixed", 1, 2, 4'b0100, 0);
        cyc(1'b1, 4'b1001, 1'b1, 1'b1, 1'b1);
        expect_res("ms rr 1001", 1, 3, 4'b1000, 0);

        // Reset mid-transaction with a competing capture
        cyc(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        expect_res("pre-reset", 1, 1, 4'b0010, 0);
        cyc(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        expect_res("mid reset", 0, 0, 0, 0);
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
        expect_res("ptr cleared", 1, 0, 4'b0001, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 63) != 0), N'($urandom), 1'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_encoder_rr.md
# req_encoder_rr

Parametrised, registered request encoder with valid/ready handshake on both sides. It accepts an N-bit request vector and returns the binary index and one-hot grant of the winning request. Arbitration is either fixed-priority (lowest index wins) or round-robin, selected per transaction. It is the sequential successor of the combinational 4:2 encoder and serves as a grant stage in front of shared resources.

## Interface
Parameters:
- N, default 8: request width; N >= 2.
- W, default $clog2(N): index width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  N  request vector; bit i = requester i.
- rr_en  in  1  arbitration mode, sampled with req: 1 = round-robin, 0 = fixed priority.
- in_valid  in  1  req/rr_en valid.
- in_ready  out  1  stage can accept.
- out_valid  out  1  result held on outputs.
- out_ready  in  1  consumer accepts the result.
- out_idx  out  W  binary index of the granted bit.
- out_onehot  out  N  one-hot grant; all-zero when nothing is granted.
- out_none  out  1  captured req was all-zero.

## Operation
- in_ready = !out_valid || out_ready (combinational; single output register, full throughput).
- Capture when in_valid && in_ready. On capture:
  - out_valid <= 1.
  - out_idx, out_onehot and out_none are computed from req, rr_en and ptr.
- Fixed priority (rr_en=0): the lowest set bit of req wins.
- Round-robin (rr_en=1): search starts at ptr, ascending, wrapping from N-1 to 0. The first set bit wins.
- Pointer ptr (W bits, internal):
  - Updates only on a capture with rr_en=1 and req != 0.
  - New value is (granted index + 1) mod N; N-1 wraps to 0.
  - Held on fixed-mode captures and on all-zero captures.
- req == 0: out_none=1, out_idx=0, out_onehot=0, ptr unchanged.
- Output handshake completes when out_valid && out_ready. With no new capture in that cycle, out_valid <= 0.
- Outputs are stable while out_valid && !out_ready. Changes on req/rr_en are ignored, because in_ready=0.
- Simultaneous output handshake and capture: the new result loads and out_valid stays 1 (back-to-back).
- Non-power-of-two N: ptr never exceeds N-1, and index values >= N are never produced.

## Timing
- Latency: 1 cycle from capture edge to out_valid/out_idx.
- Throughput: 1 result per cycle when out_ready is held high.
- Reset (rst_n=0 at an edge): out_valid=0, out_idx=0, out_onehot=0, out_none=0, ptr=0.
  - in_ready reads 1 from the cycle after reset.
  - Reset mid-transaction discards the held result with no handshake.
  - Reset has priority over capture in the same cycle.
- No combinational path from req to outputs. The only combinational path is out_ready -> in_ready.

## Test plan
All scenarios use N=4.
- Reset/fixed priority: reset, then req=4'b0110, rr_en=0 -> next cycle out_valid=1, out_idx=1, out_onehot=4'b0010, out_none=0.
- Zero request: req=4'b0000 -> out_none=1, out_idx=0, out_onehot=0. ptr unchanged; a following rr capture of 4'b1111 grants idx 0.
- Round-robin rotation: req=4'b1111 held, rr_en=1, out_ready=1 for 5 cycles -> out_idx sequence 0,1,2,3,0 (wrap). Also from ptr=3, req=4'b0101 -> idx 0, then ptr=1.
- Backpressure: capture req=4'b1000, hold out_ready=0 for 3 cycles while req changes -> in_ready=0 and out_idx=3 stable. Raise out_ready and supply req=4'b0001 the same cycle -> back-to-back result idx 0, out_valid never drops.
- Mode switch: after rr grants ptr=2, capture fixed req=4'b1100 -> idx 2 with ptr held at 3. Then rr req=4'b1001 -> idx 3.
- Reset mid-operation: out_valid=1, out_ready=0, assert rst_n=0 for one edge -> out_valid=0, ptr=0, all outputs zero.
